// File: rtl/classify_pkg.sv
// Shared constants and state encoding for the output-layer classification sequencer.
package classify_pkg;

    localparam int unsigned NUM_CLASSES = 10;
    localparam int unsigned SCORE_W     = 26;
    localparam int unsigned IDX_W       = 4;

    // Class codes outside 0-9 reported on the max output
    localparam logic [3:0] MAX_RST = 4'd15;
    localparam logic [3:0] MAX_ERR = 4'd14;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } cls_state_t;

endpackage

// File: rtl/running_max.sv
// Running signed maximum over the neuron scores of one image; ties keep the lowest index.
module running_max
    import classify_pkg::*;
#(
    parameter int unsigned P_SCORE_W = SCORE_W,
    parameter int unsigned P_IDX_W   = IDX_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic                        load,
    input  logic signed [P_SCORE_W-1:0] score,
    input  logic [P_IDX_W-1:0]          idx,
    output logic [P_IDX_W-1:0]          best_idx_next,
    output logic [P_IDX_W-1:0]          best_idx
);

    logic signed [P_SCORE_W-1:0] best;
    logic                        take_c;

    // Current score wins on the first neuron or when strictly greater than the best so far
    always_comb begin
        take_c        = (idx == '0) || (score > best);
        best_idx_next = take_c ? idx : best_idx;
    end

    // Best score/index registers, updated only when a score is consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            best     <= '0;
            best_idx <= '0;
        end else if (clear) begin
            best     <= '0;
            best_idx <= '0;
        end else if (load && take_c) begin
            best     <= score;
            best_idx <= idx;
        end
    end

endmodule

// File: rtl/classify_sequencer.sv
// Walks the neuron engine through every output neuron of one image and reports the winning class.
module classify_sequencer
    import classify_pkg::*;
#(
    parameter int unsigned P_NUM_CLASSES = NUM_CLASSES,
    parameter int unsigned P_SCORE_W     = SCORE_W,
    parameter int unsigned P_IDX_W       = IDX_W
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic                        busy,
    output logic                        neuron_req,
    output logic [P_IDX_W-1:0]          neuron_idx,
    input  logic                        neuron_ack,
    input  logic                        score_valid,
    input  logic signed [P_SCORE_W-1:0] score,
    output logic [P_IDX_W-1:0]          max,
    output logic                        done,
    output logic                        err
);

    cls_state_t         state, state_next;
    logic [P_IDX_W-1:0] idx, idx_next;
    logic [P_IDX_W-1:0] max_next;
    logic               err_next;
    logic               rm_clear, rm_load;
    logic [P_IDX_W-1:0] best_idx_next;
    logic [P_IDX_W-1:0] best_idx;
    logic               last_c;

    assign last_c     = (idx == P_IDX_W'(P_NUM_CLASSES - 1));
    assign neuron_idx = idx;

    running_max #(
        .P_SCORE_W (P_SCORE_W),
        .P_IDX_W   (P_IDX_W)
    ) u_running_max (
        .clk           (clk),
        .rst           (rst),
        .clear         (rm_clear),
        .load          (rm_load),
        .score         (score),
        .idx           (idx),
        .best_idx_next (best_idx_next),
        .best_idx      (best_idx)
    );

    // Next-state, counter and result decisions; a score outside WAIT is a protocol error
    always_comb begin
        state_next = state;
        idx_next   = idx;
        max_next   = max;
        err_next   = err;
        rm_clear   = 1'b0;
        rm_load    = 1'b0;
        case (state)
            S_IDLE: begin
                if (score_valid) begin
                    max_next   = P_IDX_W'(MAX_ERR);
                    err_next   = 1'b1;
                    state_next = S_DONE;
                end else if (start) begin
                    idx_next   = '0;
                    err_next   = 1'b0;
                    rm_clear   = 1'b1;
                    state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (score_valid) begin
                    max_next   = P_IDX_W'(MAX_ERR);
                    err_next   = 1'b1;
                    state_next = S_DONE;
                end else if (neuron_ack) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (score_valid) begin
                    rm_load = 1'b1;
                    if (last_c) begin
                        max_next   = best_idx_next;
                        state_next = S_DONE;
                    end else begin
                        idx_next   = idx + P_IDX_W'(1);
                        state_next = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State, counter and registered outputs; outputs are decoded from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= '0;
            max        <= P_IDX_W'(MAX_RST);
            err        <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            neuron_req <= 1'b0;
        end else begin
            state      <= state_next;
            idx        <= idx_next;
            max        <= max_next;
            err        <= err_next;
            done       <= (state_next == S_DONE);
            busy       <= (state_next != S_IDLE);
            neuron_req <= (state_next == S_ISSUE);
        end
    end

endmodule

// File: tb/tb_classify_sequencer.sv
// Directed bench for classify_sequencer with a small neuron-engine responder.
module tb_classify_sequencer;

    logic               clk;
    logic               rst;
    logic               start;
    logic               busy;
    logic               neuron_req;
    logic [3:0]         neuron_idx;
    logic               neuron_ack;
    logic               score_valid;
    logic signed [25:0] score;
    logic [3:0]         max;
    logic               done;
    logic               err;

    int checks = 0;
    int errors = 0;

    logic signed [25:0] sc [10];

    int r_done_cyc;
    int r_n;
    bit r_idx_ok;
    bit r_busy_ok;
    bit r_hold_ok;

    classify_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .neuron_req  (neuron_req),
        .neuron_idx  (neuron_idx),
        .neuron_ack  (neuron_ack),
        .score_valid (score_valid),
        .score       (score),
        .max         (max),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse start, then play the neuron engine until done, an injected error or an injected reset
    task automatic run_image(input int ack_dly, input int sc_dly, input int err_at,
                             input int rst_at, input bit start_in_wait);
        int         req_cnt;
        int         wcnt;
        int         cyc;
        bit         waiting;
        logic [3:0] prev_max;
        prev_max   = max;
        req_cnt    = 0;
        wcnt       = 0;
        waiting    = 1'b0;
        r_n        = 0;
        r_done_cyc = -1;
        r_idx_ok   = 1'b1;
        r_busy_ok  = 1'b1;
        r_hold_ok  = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 1;
        while (cyc < 400) begin
            neuron_ack  = 1'b0;
            score_valid = 1'b0;
            start       = 1'b0;
            if (done) begin
                r_done_cyc = cyc;
                break;
            end
            if (!busy) r_busy_ok = 1'b0;
            if (max !== prev_max) r_hold_ok = 1'b0;
            if (neuron_req) begin
                if (neuron_idx !== 4'(r_n)) r_idx_ok = 1'b0;
                if (r_n == rst_at) begin
                    rst = 1'b1;
                    break;
                end
                if (r_n == err_at) begin
                    neuron_ack  = 1'b1;
                    score_valid = 1'b1;
                    score       = '0;
                end else if (req_cnt == ack_dly) begin
                    neuron_ack = 1'b1;
                    req_cnt    = 0;
                    waiting    = 1'b1;
                    wcnt       = 0;
                end else begin
                    req_cnt++;
                end
            end else if (waiting) begin
                if (neuron_idx !== 4'(r_n)) r_idx_ok = 1'b0;
                if (start_in_wait) start = 1'b1;
                if (wcnt == sc_dly) begin
                    score_valid = 1'b1;
                    score       = sc[r_n];
                    waiting     = 1'b0;
                    r_n++;
                end else begin
                    wcnt++;
                end
            end
            tick();
            cyc++;
        end
        neuron_ack  = 1'b0;
        score_valid = 1'b0;
        start       = 1'b0;
    endtask

    // Result checks for a completed run, then confirm the return to idle one cycle later
    task automatic check_run(input string tag, input int exp_cyc, input logic [3:0] exp_max,
                             input logic exp_err, input int exp_n);
        check({tag, ".done_cycle"}, 32'(r_done_cyc), 32'(exp_cyc));
        check({tag, ".max"},        32'(max),        32'(exp_max));
        check({tag, ".err"},        32'(err),        32'(exp_err));
        check({tag, ".neurons"},    32'(r_n),        32'(exp_n));
        check({tag, ".idx_seq"},    32'(r_idx_ok),   32'd1);
        check({tag, ".busy_held"},  32'(r_busy_ok),  32'd1);
        check({tag, ".max_held"},   32'(r_hold_ok),  32'd1);
        tick();
        check({tag, ".done_drop"},  32'(done),       32'd0);
        check({tag, ".idle"},       32'(busy),       32'd0);
    endtask

    initial begin
        bit saw_done;
        rst         = 1'b1;
        start       = 1'b0;
        neuron_ack  = 1'b0;
        score_valid = 1'b0;
        score       = '0;

        // Reset held three cycles
        repeat (3) tick();
        check("rst.max",        32'(max),        32'd15);
        check("rst.busy",       32'(busy),       32'd0);
        check("rst.done",       32'(done),       32'd0);
        check("rst.neuron_req", 32'(neuron_req), 32'd0);
        check("rst.neuron_idx", 32'(neuron_idx), 32'd0);
        check("rst.err",        32'(err),        32'd0);
        rst = 1'b0;
        tick();

        // Zero-stall, scores idx*100 with idx 7 = 5000
        for (int i = 0; i < 10; i++) sc[i] = 26'(i * 100);
        sc[7] = 26'(5000);
        run_image(0, 0, -1, -1, 1'b0);
        check_run("zs", 21, 4'd7, 1'b0, 10);

        // Back-to-back start in cycle 22: negatives with a tie at -5 between idx 3 and 6
        for (int i = 0; i < 10; i++) sc[i] = 26'(-1000);
        sc[3] = 26'(-5);
        sc[6] = 26'(-5);
        run_image(0, 0, -1, -1, 1'b0);
        check_run("tie", 21, 4'd3, 1'b0, 10);

        // All scores at the most negative value: first index wins
        for (int i = 0; i < 10; i++) sc[i] = 26'h2000000;
        run_image(0, 0, -1, -1, 1'b0);
        check_run("minneg", 21, 4'd0, 1'b0, 10);

        // Engine stalls, maximum on the last neuron
        for (int i = 0; i < 10; i++) sc[i] = 26'(i * 10 - 40);
        run_image(3, 5, -1, -1, 1'b0);
        check_run("stall", 101, 4'd9, 1'b0, 10);

        // Score arriving together with ack while issuing idx 4
        for (int i = 0; i < 10; i++) sc[i] = 26'(i);
        run_image(0, 0, 4, -1, 1'b0);
        check_run("proto", 10, 4'd14, 1'b1, 4);

        // Clean run clears err; start pulses during WAIT are ignored
        for (int i = 0; i < 10; i++) sc[i] = 26'(100 - i);
        sc[2] = 26'(33554431);
        run_image(0, 0, -1, -1, 1'b1);
        check_run("clean", 21, 4'd2, 1'b0, 10);
        repeat (2) tick();
        check("wait_start.no_restart", 32'(busy), 32'd0);

        // Reset while issuing idx 5 aborts with no done pulse
        run_image(0, 0, -1, 5, 1'b0);
        check("abort.reached_idx5", 32'(r_n), 32'd5);
        tick();
        rst = 1'b0;
        check("abort.max",        32'(max),        32'd15);
        check("abort.busy",       32'(busy),       32'd0);
        check("abort.done",       32'(done),       32'd0);
        check("abort.neuron_req", 32'(neuron_req), 32'd0);
        check("abort.neuron_idx", 32'(neuron_idx), 32'd0);
        check("abort.err",        32'(err),        32'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done || busy) saw_done = 1'b1;
        end
        check("abort.quiet", 32'(saw_done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/classify_sequencer.md
# classify_sequencer

Sequences the shared dot-product engine through the output-layer neurons of one image and tracks the running signed maximum of their scores, producing the predicted digit class. It sits between the top-level image controller, which pulses `start`, and the neuron engine, which returns one score per requested neuron. Class encoding matches the existing classifier output: 0–9 is a valid class, 15 means in reset, 14 means error.

## Interface
- `NUM_CLASSES`, 10, number of output neurons sequenced per image
- `SCORE_W`, 26, signed score width
- `IDX_W`, 4, class/neuron index width
- `clk`  in  1  single system clock, all logic on posedge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request to classify the current image; honoured only in IDLE
- `busy`  out  1  high whenever state ≠ IDLE
- `neuron_req`  out  1  request to neuron engine; high only in ISSUE
- `neuron_idx`  out  IDX_W  neuron being requested or awaited
- `neuron_ack`  in  1  engine accepted the request this cycle
- `score_valid`  in  1  `score` is valid this cycle
- `score`  in  SCORE_W  signed two's-complement neuron score
- `max`  out  IDX_W  registered predicted class; holds until next result or reset
- `done`  out  1  one-cycle pulse; `max` and `err` are valid in the same cycle
- `err`  out  1  registered; set with `done` when the run ended in protocol error

## Operation
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE: `start` → ISSUE. Clear `idx` to 0 and `err` to 0; best score/index are don't-care.
- ISSUE: `neuron_req`=1, `neuron_idx`=`idx`. `neuron_ack` → WAIT. Otherwise stay; no timeout.
- WAIT: on `score_valid`, update running max:
  - If `idx`==0, or `$signed(score)` > `$signed(best)`, then `best`←`score` and `best_idx`←`idx`.
  - Strict `>` means ties resolve to the lowest index.
  - If `idx`==NUM_CLASSES-1: load `max` with the final winner (including the current score), then go to DONE.
  - Otherwise `idx`←`idx`+1 and go to ISSUE.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- Protocol error: `score_valid`=1 in IDLE or ISSUE, including simultaneously with `neuron_ack`.
  - Response: `max`←14, `err`←1, go to DONE, which pulses `done`.
  - `score_valid` in DONE is ignored.
- `start` outside IDLE is ignored; it is not queued.
- Comparisons are full SCORE_W signed. No truncation or saturation.

## Timing
- Reset values: state IDLE, `max`=15, `err`=0, `done`=0, `busy`=0, `neuron_req`=0, `neuron_idx`=0.
- `rst` mid-run aborts immediately to reset values. No `done` is generated for the aborted run.
- `start` sampled high in cycle 0 gives ISSUE in cycle 1.
- Each neuron costs 1 ISSUE cycle plus 1 WAIT cycle minimum. Engine stalls extend either state.
- Zero-stall run: `done`=1 in cycle 21 (= 2·NUM_CLASSES+1). A new `start` is accepted in cycle 22.
- `neuron_idx` is registered and stable through each ISSUE/WAIT pair.
- `max` changes only on the edge entering DONE, or on reset.

## Structure
- Package `classify_pkg`:
  - NUM_CLASSES, SCORE_W, IDX_W.
  - MAX_RST=4'd15, MAX_ERR=4'd14.
  - State enum `cls_state_t`.
- Sub-module `running_max`:
  - Holds `best`/`best_idx` registers and the signed comparator.
  - Inputs: `clk`, `rst`, `clear`, `load`, `score`, `idx`.
  - Outputs: `best_idx_next` (combinational winner including the current score) and `best_idx`.
- The FSM and counter live in `classify_sequencer`.

## Test plan
- Reset check: hold `rst` 3 cycles → `max`=15, `busy`=0, `done`=0, `neuron_req`=0.
- Zero-stall run, ack immediate, scores 1 cycle after ack, scores = idx·100 with idx 7 = 5000 → `done` in cycle 21, `max`=7, `err`=0, `neuron_idx` sequence 0..9.
- Negative scores and ties: all scores −1000 except idx 3 and idx 6 = −5 → `max`=3. Repeat with all ten scores equal to −(2^25) → `max`=0.
- Engine stalls: ack delayed 3 cycles and score delayed 5 cycles per neuron, max at idx 9 → `max`=9, `done` in cycle 1+10·(4+6)=101, `busy` high throughout.
- Protocol error: `score_valid` asserted during ISSUE for idx 4 → next cycle `done`=1, `err`=1, `max`=14, then IDLE. Next clean run clears `err`.
- `start` asserted during WAIT is ignored. `rst` asserted at idx 5 → reset values next cycle, no `done` pulse.
